// File: rtl/branch_resolver_pkg.sv
// Shared types and configuration for the execute-stage branch resolver.
// The taken decode lives here so the branch predictor's update path can reuse it.
package branch_resolver_pkg;

  localparam int DEFAULT_COUNTER_WIDTH = 16;

  typedef logic [31:0] InstAddr;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5,
    JAL  = 3'd6,
    JALR = 3'd7
  } BranchOp;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } ResolverState;

  function automatic logic isBranchTaken(
    input BranchOp op,
    input logic    isEqual,
    input logic    isLessSigned,
    input logic    isLessUnsigned
  );
    logic taken;
    // NOTE: a default before the case keeps every path assigned, so no latch can appear.
    taken = 1'b1;
    case (op)
      BEQ:       taken = isEqual;
      BNE:       taken = !isEqual;
      BLT:       taken = isLessSigned;
      BGE:       taken = !isLessSigned;
      BLTU:      taken = isLessUnsigned;
      BGEU:      taken = !isLessUnsigned;
      JAL, JALR: taken = 1'b1;
      default:   taken = 1'b1;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_resolver_SaturatingCounter.sv
// Counter that sticks at all-ones; a synchronous clear wins over an increment.
module branch_resolver_SaturatingCounter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_increment,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_increment && (o_count != '1)) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: taken decode, mispredict detection, registered
// redirect handshake to fetch with a one-cycle flush, and saturating perf counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [2:0]               i_op,
  input  logic                     i_isEqual,
  input  logic                     i_isLessSigned,
  input  logic                     i_isLessUnsigned,
  input  logic [31:0]              i_pc,
  input  logic [31:0]              i_target,
  input  logic                     i_predictedTaken,
  input  logic [31:0]              i_predictedTarget,
  output logic                     o_redirectValid,
  input  logic                     i_redirectReady,
  output logic [31:0]              o_redirectAddr,
  output logic                     o_flush,
  input  logic                     i_clearCounters,
  output logic [COUNTER_WIDTH-1:0] o_branchCount,
  output logic [COUNTER_WIDTH-1:0] o_mispredictCount
);

  ResolverState state;
  BranchOp      op;
  InstAddr      alignedTarget;
  InstAddr      actualNextPc;
  logic         taken;
  logic         mispredict;
  logic         accept;
  logic         readyReg;

  assign op     = BranchOp'(i_op);
  assign accept = i_valid && readyReg;

  always_comb begin
    alignedTarget = i_target;
    if (op == JALR) begin
      alignedTarget[0] = 1'b0;
    end
    taken        = isBranchTaken(op, i_isEqual, i_isLessSigned, i_isLessUnsigned);
    actualNextPc = taken ? alignedTarget : i_pc + 32'd4;
    mispredict   = (taken != i_predictedTaken) || (actualNextPc != i_predictedTarget);
  end

  // Ready is a register driven by the state machine alone, so fetch-side
  // handshake inputs never reach o_ready combinationally.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state           <= IDLE;
      readyReg        <= 1'b1;
      o_redirectValid <= 1'b0;
      o_flush         <= 1'b0;
      o_redirectAddr  <= '0;
    end else begin
      o_flush <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && mispredict) begin
            state           <= REDIRECT;
            readyReg        <= 1'b0;
            o_redirectValid <= 1'b1;
            o_flush         <= 1'b1;
            o_redirectAddr  <= actualNextPc;
          end
        end
        REDIRECT: begin
          if (i_redirectReady) begin
            state           <= IDLE;
            readyReg        <= 1'b1;
            o_redirectValid <= 1'b0;
          end
        end
        default: begin
          state           <= IDLE;
          readyReg        <= 1'b1;
          o_redirectValid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = readyReg;

  branch_resolver_SaturatingCounter #(.WIDTH(COUNTER_WIDTH)) branchCounter (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_increment (accept),
    .i_clear     (i_clearCounters),
    .o_count     (o_branchCount)
  );

  branch_resolver_SaturatingCounter #(.WIDTH(COUNTER_WIDTH)) mispredictCounter (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_increment (accept && mispredict),
    .i_clear     (i_clearCounters),
    .o_count     (o_mispredictCount)
  );

endmodule
